// File: rtl/sincos_arbiter_if.sv
// Bundle of requester, shared sin_cos unit and response signals
// seen by the sincos_arbiter.
interface sincos_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_in;
    logic        req0_sel;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_in;
    logic        req1_sel;
    logic [31:0] sincos_in;
    logic        sincos_sel;
    logic [31:0] sincos_result;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_id;
    logic        resp_invalid;
    logic        busy;

    modport slave (
        input  req0_valid, req0_in, req0_sel,
        output req0_ready,
        input  req1_valid, req1_in, req1_sel,
        output req1_ready,
        output sincos_in, sincos_sel,
        input  sincos_result,
        output resp_valid, resp_data, resp_id, resp_invalid,
        input  resp_ready,
        output busy
    );

    modport master (
        output req0_valid, req0_in, req0_sel,
        input  req0_ready,
        output req1_valid, req1_in, req1_sel,
        input  req1_ready,
        input  sincos_in, sincos_sel,
        output sincos_result,
        input  resp_valid, resp_data, resp_id, resp_invalid,
        output resp_ready,
        input  busy
    );
endinterface

// File: rtl/sincos_arbiter.sv
// Round-robin arbiter sharing one combinational sin_cos unit
// between two requesters, with a fixed settle time per operation.
module sincos_arbiter #(
    parameter int SETTLE_CYCLES = 2
) (
    input logic            clk,
    input logic            rst,
    sincos_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RESP
    } state_t;

    localparam logic [3:0]  SC  = 4'(SETTLE_CYCLES);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    state_t      state_q;
    logic        ptr_q;
    logic [3:0]  cnt_q;
    logic [31:0] op_q;
    logic        sel_q;
    logic        id_q;
    logic        valid_q;
    logic        inv_q;
    logic [31:0] data_q;

    logic gnt;
    logic idle;
    logic accept;
    logic op_bad;

    // Pointer only matters when both requesters compete.
    always_comb begin
        gnt = ptr_q;
        if (!(bus.req0_valid && bus.req1_valid))
            gnt = bus.req1_valid;
    end

    assign idle           = (state_q == IDLE);
    assign bus.req0_ready = idle && bus.req0_valid && !gnt;
    assign bus.req1_ready = idle && bus.req1_valid && gnt;
    assign accept         = bus.req0_ready || bus.req1_ready;
    assign op_bad         = &op_q[30:23];

    assign bus.sincos_in    = op_q;
    assign bus.sincos_sel   = sel_q;
    assign bus.resp_valid   = valid_q;
    assign bus.resp_data    = data_q;
    assign bus.resp_id      = id_q;
    assign bus.resp_invalid = inv_q;
    assign bus.busy         = !idle;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            cnt_q   <= 4'd0;
            op_q    <= 32'd0;
            sel_q   <= 1'b0;
            id_q    <= 1'b0;
            valid_q <= 1'b0;
            inv_q   <= 1'b0;
            data_q  <= 32'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q    <= gnt ? bus.req1_in : bus.req0_in;
                        sel_q   <= gnt ? bus.req1_sel : bus.req0_sel;
                        id_q    <= gnt;
                        ptr_q   <= ~gnt;
                        cnt_q   <= SC;
                        state_q <= SETTLE;
                    end
                end
                SETTLE: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        data_q  <= op_bad ? QNAN : bus.sincos_result;
                        inv_q   <= op_bad;
                        valid_q <= 1'b1;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sincos_arbiter.sv
// Bench for sincos_arbiter: vector table, hand sequences for
// contention and reset, and randomized ops against a model.
module tb_sincos_arbiter;
    localparam int N = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic ptr_m = 1'b0;

    sincos_arbiter_if bus ();

    sincos_arbiter #(.SETTLE_CYCLES(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Stand-in for the shared sin_cos unit.
    function automatic logic [31:0] unit(input logic [31:0] x, input logic s);
        if (x == 32'h3FC9_0FDB && s)  return 32'h3F80_0000;
        if (x == 32'h0000_0000 && !s) return 32'h3F80_0000;
        if (x == 32'h4049_0FDB && !s) return 32'hBF80_0000;
        if (x == 32'h3F49_0FDB && s)  return 32'h3F35_04F3;
        return x ^ {s, 31'h0} ^ 32'h1357_9BDF;
    endfunction

    assign bus.sincos_result = unit(bus.sincos_in, bus.sincos_sel);

    typedef struct {
        logic        v0;
        logic [31:0] i0;
        logic        s0;
        logic        v1;
        logic [31:0] i1;
        logic        s1;
        int          hold;
        logic        eid;
        logic [31:0] edata;
        logic        einv;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] a,
                       input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic scramble();
        bus.req0_in  = $urandom;
        bus.req1_in  = $urandom;
        bus.req0_sel = 1'($urandom);
        bus.req1_sel = 1'($urandom);
    endtask

    task automatic do_op(input logic v0, input logic [31:0] i0,
                         input logic s0, input logic v1,
                         input logic [31:0] i1, input logic s1,
                         input int hold, input logic eid,
                         input logic [31:0] edata, input logic einv);
        int lat;
        int quiet;
        bus.req0_valid = v0;
        bus.req0_in    = i0;
        bus.req0_sel   = s0;
        bus.req1_valid = v1;
        bus.req1_in    = i1;
        bus.req1_sel   = s1;
        #1;
        chk("grant0", 64'(bus.req0_ready), 64'(eid == 1'b0));
        chk("grant1", 64'(bus.req1_ready), 64'(eid == 1'b1));
        @(posedge clk);
        #1;
        chk("operand", 64'(bus.sincos_in), 64'(eid ? i1 : i0));
        chk("opsel", 64'(bus.sincos_sel), 64'(eid ? s1 : s0));
        lat   = 0;
        quiet = 0;
        while (!bus.resp_valid && lat < 40) begin
            if (bus.req0_ready || bus.req1_ready || !bus.busy)
                quiet++;
            scramble();
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'(N));
        chk("data", 64'(bus.resp_data), 64'(edata));
        chk("id", 64'(bus.resp_id), 64'(eid));
        chk("invalid", 64'(bus.resp_invalid), 64'(einv));
        for (int h = 0; h <= hold; h++) begin
            if (!bus.resp_valid || bus.resp_data !== edata ||
                bus.resp_id !== eid || bus.resp_invalid !== einv ||
                bus.req0_ready || bus.req1_ready || !bus.busy)
                quiet++;
            scramble();
            if (h == hold)
                bus.resp_ready = 1'b1;
            #1;
            if (bus.req0_ready || bus.req1_ready)
                quiet++;
            @(posedge clk);
            #1;
        end
        bus.resp_ready = 1'b0;
        chk("quiet", 64'(quiet), 64'd0);
        chk("release", {62'd0, bus.resp_valid, bus.busy}, 64'd0);
    endtask

    task automatic rst_check(input string nm);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk({nm, "_sc"}, {31'd0, bus.sincos_sel, bus.sincos_in}, 64'd0);
        chk({nm, "_resp"}, {29'd0, bus.resp_valid, bus.resp_id,
            bus.resp_invalid, bus.resp_data}, 64'd0);
        chk({nm, "_busy"}, 64'(bus.busy), 64'd0);
        rst = 1'b0;
        ptr_m = 1'b0;
    endtask

    vec_t vt[7];

    initial begin
        logic        v0, v1, s0, s1, g;
        logic [31:0] i0, i1, op, ed;
        int          pat;

        vt[0] = '{1, 32'h3FC9_0FDB, 1, 0, 32'h0, 0, 0, 0, 32'h3F80_0000, 0};
        vt[1] = '{1, 32'h7F80_0000, 0, 0, 32'h0, 0, 2, 0, 32'h7FC0_0000, 1};
        vt[2] = '{0, 32'h0, 0, 1, 32'h7FFF_FFFF, 1, 0, 1, 32'h7FC0_0000, 1};
        vt[3] = '{1, 32'h0, 0, 1, 32'h4049_0FDB, 0, 1, 0, 32'h3F80_0000, 0};
        vt[4] = '{1, 32'h0, 0, 1, 32'h4049_0FDB, 0, 0, 1, 32'hBF80_0000, 0};
        vt[5] = '{0, 32'h0, 0, 1, 32'h3F49_0FDB, 1, 10, 1, 32'h3F35_04F3, 0};
        vt[6] = '{1, 32'hFF80_0000, 1, 0, 32'h0, 0, 0, 0, 32'h7FC0_0000, 1};

        bus.req0_valid = 1'b0;
        bus.req0_in    = 32'd0;
        bus.req0_sel   = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req1_in    = 32'd0;
        bus.req1_sel   = 1'b0;
        bus.resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_check("reset");

        foreach (vt[k])
            do_op(vt[k].v0, vt[k].i0, vt[k].s0, vt[k].v1, vt[k].i1,
                  vt[k].s1, vt[k].hold, vt[k].eid, vt[k].edata,
                  vt[k].einv);

        // Both requesters held valid from reset: strict alternation.
        rst_check("reset2");
        for (int k = 0; k < 8; k++)
            do_op(1, 32'h0, 0, 1, 32'h4049_0FDB, 0, 0, 1'(k),
                  k[0] ? 32'hBF80_0000 : 32'h3F80_0000, 0);

        // Reset in the middle of SETTLE, then of RESP.
        rst_check("reset3");
        bus.req1_valid = 1'b1;
        bus.req1_in    = 32'h3F49_0FDB;
        bus.req1_sel   = 1'b1;
        @(posedge clk);
        #1;
        rst_check("rst_settle");
        bus.req0_valid = 1'b1;
        bus.req0_in    = 32'h3FC9_0FDB;
        bus.req0_sel   = 1'b1;
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        repeat (N) @(posedge clk);
        #1;
        chk("pre_rst_resp", 64'(bus.resp_valid), 64'd1);
        rst_check("rst_resp");
        do_op(0, 32'h0, 0, 1, 32'h3F49_0FDB, 1, 0, 1, 32'h3F35_04F3, 0);

        // Randomized ops against the transaction-level model.
        rst_check("reset4");
        for (int k = 0; k < 40; k++) begin
            pat = $urandom_range(1, 3);
            v0  = pat[0];
            v1  = pat[1];
            i0  = $urandom;
            i1  = $urandom;
            if ($urandom_range(0, 3) == 0) i0[30:23] = 8'hFF;
            if ($urandom_range(0, 3) == 0) i1[30:23] = 8'hFF;
            s0  = 1'($urandom);
            s1  = 1'($urandom);
            g   = (v0 && v1) ? ptr_m : v1;
            op  = g ? i1 : i0;
            ed  = (op[30:23] == 8'hFF) ? 32'h7FC0_0000
                                       : unit(op, g ? s1 : s0);
            do_op(v0, i0, s0, v1, i1, s1, $urandom_range(0, 3), g, ed,
                  op[30:23] == 8'hFF);
            ptr_m = ~g;
        end

        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
